// File: rtl/usb_stream_duplex.sv
// FT2232/FT245 async-FIFO bridge: TX word FIFO serialised LSB byte first, RX byte FIFO, one shared-bus FSM.
// Define USB_STREAM_OVF_CNT_EN to add the saturating tx_ovf_count output for dropped TX words.
module usb_stream_duplex #(
  parameter int DATA_WIDTH     = 8,
  parameter int TX_LOG_SIZE    = 13,
  parameter int RX_LOG_SIZE    = 9,
  parameter int FIFO_THRESHOLD = 8,
  parameter int RD_PULSE       = 4
) (
  input  logic                  mclk,
  input  logic                  reset,
  inout  wire  [7:0]            usb_d,
  input  logic                  usb_rxf_n,
  input  logic                  usb_txe_n,
  output logic                  usb_rd_n,
  output logic                  usb_wr_n,
  output logic                  usb_oe_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_wr,
  output logic                  tx_have_space,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_rd
`ifdef USB_STREAM_OVF_CNT_EN
  ,output logic [15:0]          tx_ovf_count
`endif
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W    = $clog2(RD_PULSE + 1);
  localparam int TX_DEPTH = 2 ** TX_LOG_SIZE;
  localparam int RX_DEPTH = 2 ** RX_LOG_SIZE;
  localparam logic [TX_LOG_SIZE:0] SPACE_LIM = (TX_LOG_SIZE + 1)'(TX_DEPTH - FIFO_THRESHOLD);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]     CNT_INIT  = CNT_W'(RD_PULSE - 1);

  // state | meaning: IDLE arbitrate, bus Z | TX_SETUP drive byte | TX_STROBE wr_n low
  // TX_HOLD data hold | RX_STROBE rd_n low, capture on last cycle | TURN bus turnaround
  typedef enum logic [2:0] {IDLE, TX_SETUP, TX_STROBE, TX_HOLD, RX_STROBE, TURN} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   tx_mem [TX_DEPTH];
  logic [7:0]              rx_mem [RX_DEPTH];
  logic [TX_LOG_SIZE-1:0]  tx_wr_ptr, tx_rd_ptr, tx_used;
  logic [RX_LOG_SIZE-1:0]  rx_wr_ptr, rx_rd_ptr, rx_used;
  logic [IDX_W-1:0]        byte_idx;
  logic [CNT_W-1:0]        rd_cnt;
  logic [7:0]              d_out, cur_byte;
  logic                    drive_en, wr_n_q, rd_n_q, last_tx;
  logic                    tx_full, tx_empty, rx_full, tx_req, rx_req;
  logic                    tx_push, tx_pop, rx_push, rx_pop;

  assign tx_used       = tx_wr_ptr - tx_rd_ptr;
  assign tx_full       = &tx_used;
  assign tx_empty      = (tx_wr_ptr == tx_rd_ptr);
  assign tx_have_space = {1'b0, tx_used} < SPACE_LIM;
  assign rx_used       = rx_wr_ptr - rx_rd_ptr;
  assign rx_full       = &rx_used;
  assign rx_valid      = (rx_wr_ptr != rx_rd_ptr);
  assign rx_data       = rx_mem[rx_rd_ptr];

  assign cur_byte = 8'(tx_mem[tx_rd_ptr] >> {byte_idx, 3'b000});
  assign tx_req   = ~tx_empty & ~usb_txe_n;
  assign rx_req   = ~usb_rxf_n & ~rx_full;
  assign tx_push  = tx_wr & ~tx_full;
  assign tx_pop   = (state == TX_STROBE) && (byte_idx == LAST_IDX);
  assign rx_push  = (state == RX_STROBE) && (rd_cnt == '0);
  assign rx_pop   = rx_rd & rx_valid;

  assign usb_d    = drive_en ? d_out : 8'bz;
  assign usb_oe_n = 1'b1;
  assign usb_wr_n = wr_n_q;
  assign usb_rd_n = rd_n_q;

  // Storage carries no reset: pointer reset alone discards the contents.
  always_ff @(posedge mclk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= usb_d;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      drive_en <= 1'b0;
      d_out    <= '0;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      byte_idx <= '0;
      rd_cnt   <= '0;
      last_tx  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_req && (!rx_req || !last_tx)) begin
            state    <= TX_SETUP;
            last_tx  <= 1'b1;
            drive_en <= 1'b1;
            d_out    <= cur_byte;
          end else if (rx_req) begin
            state   <= RX_STROBE;
            last_tx <= 1'b0;
            rd_n_q  <= 1'b0;
            rd_cnt  <= CNT_INIT;
          end
        end
        TX_SETUP: begin
          if (usb_txe_n) begin
            state    <= IDLE;
            drive_en <= 1'b0;
          end else begin
            state  <= TX_STROBE;
            wr_n_q <= 1'b0;
          end
        end
        TX_STROBE: begin
          state    <= TX_HOLD;
          wr_n_q   <= 1'b1;
          byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
        end
        TX_HOLD: begin
          state    <= IDLE;
          drive_en <= 1'b0;
        end
        RX_STROBE: begin
          if (rd_cnt == '0) begin
            state  <= TURN;
            rd_n_q <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USB_STREAM_OVF_CNT_EN
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset)
      tx_ovf_count <= '0;
    else if (tx_wr && tx_full && tx_ovf_count != 16'hFFFF)
      tx_ovf_count <= tx_ovf_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_usb_stream_duplex.sv
// Directed bench for usb_stream_duplex: vector tables for TX/RX bytes plus hand-written
// sequences for retry, interleave, FIFO full and mid-transfer reset.
module tb_usb_stream_duplex;
  localparam int DW = 16;

  logic          mclk = 1'b0;
  logic          reset = 1'b0;
  wire  [7:0]    usb_d;
  logic          usb_rxf_n = 1'b1, usb_txe_n = 1'b1;
  logic          usb_rd_n, usb_wr_n, usb_oe_n;
  logic [DW-1:0] tx_data = '0;
  logic          tx_wr = 1'b0, tx_have_space;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_rd = 1'b0;
  logic          host_en = 1'b0;
  logic [7:0]    host_d = 8'h00;
`ifdef USB_STREAM_OVF_CNT_EN
  logic [15:0]   tx_ovf_count;
`endif

  int         n_cmp = 0, n_err = 0, viol = 0, cyc = 0;
  logic [7:0] tx_q[$];
  int         wr_cyc[$];
  bit         grant_log[$];
  logic       rd_prev = 1'b1;

  typedef struct { logic [15:0] word; logic [7:0] b0; logic [7:0] b1; } tx_vec_t;
  typedef struct { logic [7:0] host; logic [7:0] exp; } rx_vec_t;
  tx_vec_t tv[3];
  rx_vec_t rv[3];

  // Host drives the bus only while the DUT strobes a read, as the FT2232 does.
  assign usb_d = (host_en && !usb_rd_n) ? host_d : 8'bz;
  always #5 mclk = ~mclk;

  usb_stream_duplex #(
    .DATA_WIDTH(DW), .TX_LOG_SIZE(4), .RX_LOG_SIZE(4), .FIFO_THRESHOLD(8), .RD_PULSE(4)
  ) dut (
    .mclk(mclk), .reset(reset), .usb_d(usb_d), .usb_rxf_n(usb_rxf_n), .usb_txe_n(usb_txe_n),
    .usb_rd_n(usb_rd_n), .usb_wr_n(usb_wr_n), .usb_oe_n(usb_oe_n),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_have_space(tx_have_space),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd)
`ifdef USB_STREAM_OVF_CNT_EN
    , .tx_ovf_count(tx_ovf_count)
`endif
  );

  always @(negedge mclk) begin
    cyc++;
    if (!usb_wr_n) begin
      tx_q.push_back(usb_d);
      wr_cyc.push_back(cyc);
      grant_log.push_back(1'b1);
    end
    if (!usb_rd_n && rd_prev) grant_log.push_back(1'b0);
    if ((!usb_rd_n || !rd_prev) && dut.drive_en) viol++;
    rd_prev = usb_rd_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    tx_data = w;
    tx_wr   = 1'b1;
    step();
    tx_wr   = 1'b0;
  endtask

  task automatic wait_txq(input int n, input int bound, input string name);
    int i = 0;
    while (tx_q.size() < n && i < bound) begin
      step();
      i++;
    end
    check(name, tx_q.size(), n);
  endtask

  task automatic rx_one(input logic [7:0] v, input logic [7:0] exp, input bit pop);
    int i = 0;
    int low = 0;
    host_d    = v;
    host_en   = 1'b1;
    usb_rxf_n = 1'b0;
    while (usb_rd_n && i < 20) begin
      step();
      i++;
    end
    while (!usb_rd_n && low < 20) begin
      low++;
      step();
    end
    usb_rxf_n = 1'b1;
    host_en   = 1'b0;
    step();
    check("rx_rd_low_cycles", low, 4);
    check("rx_valid_after_push", rx_valid, 1'b1);
    check("rx_data", rx_data, exp);
    if (pop) begin
      rx_rd = 1'b1;
      step();
      rx_rd = 1'b0;
      check("rx_valid_after_pop", rx_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{16'hA55A, 8'h5A, 8'hA5};
    tv[1] = '{16'h1234, 8'h34, 8'h12};
    tv[2] = '{16'h00FF, 8'hFF, 8'h00};
    rv[0] = '{8'h3C, 8'h3C};
    rv[1] = '{8'hA7, 8'hA7};
    rv[2] = '{8'h00, 8'h00};

    repeat (3) step();
    check("rst_wr_n", usb_wr_n, 1'b1);
    check("rst_rd_n", usb_rd_n, 1'b1);
    check("rst_oe_n", usb_oe_n, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_have_space", tx_have_space, 1'b1);
    check("rst_drive_en", dut.drive_en, 1'b0);
    reset = 1'b1;
    step();

    for (int k = 0; k < 3; k++) begin
      tx_q.delete();
      wr_cyc.delete();
      push(tv[k].word);
      usb_txe_n = 1'b0;
      wait_txq(2, 40, "tx_byte_count");
      repeat (6) step();
      check("tx_byte0", tx_q[0], tv[k].b0);
      check("tx_byte1", tx_q[1], tv[k].b1);
      check("tx_no_extra_strobe", tx_q.size(), 2);
      check("tx_strobe_spacing", wr_cyc[1] - wr_cyc[0], 4);
      check("tx_fifo_empty", dut.tx_wr_ptr == dut.tx_rd_ptr, 1'b1);
      usb_txe_n = 1'b1;
    end

    // TX retry: txe_n deasserts during TX_SETUP of byte 8'h11.
    tx_q.delete();
    push(16'h2211);
    usb_txe_n = 1'b0;
    step();
    check("retry_setup_state", {usb_wr_n, dut.drive_en}, 2'b11);
    usb_txe_n = 1'b1;
    repeat (6) step();
    check("retry_no_strobe", tx_q.size(), 0);
    usb_txe_n = 1'b0;
    wait_txq(2, 40, "retry_byte_count");
    repeat (6) step();
    check("retry_byte0", tx_q[0], 8'h11);
    check("retry_byte1", tx_q[1], 8'h22);
    check("retry_once", tx_q.size(), 2);
    usb_txe_n = 1'b1;

    for (int k = 0; k < 3; k++) rx_one(rv[k].host, rv[k].exp, 1'b1);

    // Interleave: both sides request continuously, last grant was RX.
    tx_q.delete();
    grant_log.delete();
    push(16'h0201);
    push(16'h0403);
    host_d    = 8'h77;
    host_en   = 1'b1;
    usb_rxf_n = 1'b0;
    usb_txe_n = 1'b0;
    begin
      int i = 0;
      while (tx_q.size() < 4 && i < 200) begin
        step();
        i++;
      end
    end
    usb_rxf_n = 1'b1;
    repeat (10) step();
    host_en = 1'b0;
    usb_txe_n = 1'b1;
    begin
      logic [6:0] g = '0;
      int n = 0;
      int bad = 0;
      for (int k = 0; k < 7 && k < grant_log.size(); k++) g[6-k] = grant_log[k];
      check("grant_count", grant_log.size(), 7);
      check("grant_order", g, 7'b1010101);
      check("interleave_word", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h04030201);
      while (rx_valid && n < 20) begin
        if (rx_data !== 8'h77) bad++;
        rx_rd = 1'b1;
        step();
        rx_rd = 1'b0;
        n++;
      end
      check("interleave_rx_count", n, 3);
      check("interleave_rx_data_bad", bad, 0);
    end

    // Fill: 20 writes into a 15-word FIFO with the host not accepting.
    for (int i = 0; i < 20; i++) begin
      tx_data = DW'(i);
      tx_wr   = 1'b1;
      step();
      if (i == 6) check("space_at_7_used", tx_have_space, 1'b1);
      if (i == 7) check("space_at_8_used", tx_have_space, 1'b0);
    end
    tx_wr = 1'b0;
`ifdef USB_STREAM_OVF_CNT_EN
    check("ovf_count", tx_ovf_count, 16'd5);
`endif
    tx_q.delete();
    usb_txe_n = 1'b0;
    wait_txq(30, 300, "full_byte_count");
    repeat (8) step();
    check("full_no_extra", tx_q.size(), 30);
    check("full_first_word", {tx_q[1], tx_q[0]}, 16'd0);
    check("full_last_word", {tx_q[29], tx_q[28]}, 16'd14);
    check("space_after_drain", tx_have_space, 1'b1);
    usb_txe_n = 1'b1;

    // Reset during RX_STROBE with data queued in both FIFOs.
    rx_one(8'h99, 8'h99, 1'b0);
    push(16'hDEAD);
    host_d    = 8'hC3;
    host_en   = 1'b1;
    usb_rxf_n = 1'b0;
    begin
      int i = 0;
      while (usb_rd_n && i < 20) begin
        step();
        i++;
      end
    end
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_rd_n", usb_rd_n, 1'b1);
    check("rst_mid_rx_valid", rx_valid, 1'b0);
    check("rst_mid_rx_ptrs", {dut.rx_wr_ptr, dut.rx_rd_ptr}, 8'h00);
    check("rst_mid_tx_ptrs", {dut.tx_wr_ptr, dut.tx_rd_ptr}, 8'h00);
    usb_rxf_n = 1'b1;
    host_en   = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    rx_one(8'h5E, 8'h5E, 1'b1);
    tx_q.delete();
    push(16'hBEEF);
    usb_txe_n = 1'b0;
    wait_txq(2, 40, "post_rst_byte_count");
    repeat (6) step();
    check("post_rst_word", {tx_q[1], tx_q[0]}, 16'hBEEF);
    check("post_rst_no_stale", tx_q.size(), 2);
    usb_txe_n = 1'b1;

    check("bus_turnaround_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/usb_stream_duplex.md
Name: usb_stream_duplex

Overview:
- Next-generation FT2232/FT245 async-FIFO bridge.
- Full-duplex with respect to the user logic: a TX FIFO of DATA_WIDTH-bit words is serialised LSB byte first onto usb_d, and host-to-device bytes are read into an RX FIFO.
- A single bus state machine arbitrates the shared usb_d pins between TX and RX and owns turnaround and retry.
- Sits between capture/command logic and the FT2232 channel pins.

Parameters:
- DATA_WIDTH, 8: TX word width; multiple of 8, 8..32.
- TX_LOG_SIZE, 13: log2 of TX FIFO depth in words.
- RX_LOG_SIZE, 9: log2 of RX FIFO depth in bytes.
- FIFO_THRESHOLD, 8: TX headroom in words for tx_have_space.
- RD_PULSE, 4: mclk cycles usb_rd_n is held low per RX byte; must be >= 2.

Ports:
- mclk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- usb_d  inout  8  FT2232 data bus
- usb_rxf_n  in  1  FT2232 RX-data-available, active-low
- usb_txe_n  in  1  FT2232 TX-space-available, active-low
- usb_rd_n  out  1  read strobe, active-low
- usb_wr_n  out  1  write strobe, active-low
- usb_oe_n  out  1  tied 1 (async 245 mode)
- tx_data  in  DATA_WIDTH  word to stream to host
- tx_wr  in  1  push tx_data
- tx_have_space  out  1  TX used words < 2**TX_LOG_SIZE - FIFO_THRESHOLD
- rx_data  out  8  head byte of RX FIFO (first-word fall-through)
- rx_valid  out  1  RX FIFO non-empty
- rx_rd  in  1  pop RX head; ignored when rx_valid=0

Behaviour:
- Reset is asynchronous, active-low; clock is mclk. Under reset:
  - usb_wr_n=1, usb_rd_n=1, usb_d released (Z), state=IDLE.
  - Both FIFO pointers = 0, rx_valid=0, byte index=0, last_grant=RX.
  - Reset mid-transfer aborts immediately; a partially sent word and all FIFO contents are discarded.
- TX FIFO:
  - Usable capacity is 2**TX_LOG_SIZE-1 words.
  - tx_wr while full drops the word.
  - Pointer arithmetic is modulo 2**TX_LOG_SIZE.
  - Simultaneous push and pop are both honoured.
- TX serialiser: the byte index counts 0..DATA_WIDTH/8-1; byte k = tx_data[8k+7:8k]. The word is popped only when its last byte is strobed.
- RX FIFO:
  - Capacity is 2**RX_LOG_SIZE-1 bytes.
  - Simultaneous push and rx_rd are allowed.
  - rx_data and rx_valid update the cycle after a push into an empty FIFO.
- Requests in IDLE:
  - tx_req = TX FIFO non-empty & !usb_txe_n.
  - rx_req = !usb_rxf_n & RX FIFO not full.
- States:
  - IDLE: bus Z, both strobes 1.
    - tx_req only -> TX_SETUP; rx_req only -> RX_STROBE.
    - Both -> the side not equal to last_grant; last_grant updates on each grant.
  - TX_SETUP: drive the current byte, wr_n=1.
    - If usb_txe_n=1 this cycle -> IDLE with no strobe and no index advance (retry later, same byte).
    - Else -> TX_STROBE.
  - TX_STROBE: wr_n=0, byte still driven; the byte index advances (word pop on last byte) -> TX_HOLD.
  - TX_HOLD: wr_n=1, data held -> IDLE. A TX byte costs 4 cycles, IDLE included.
  - RX_STROBE: rd_n=0 for RD_PULSE cycles, bus Z. usb_d is captured and pushed on the last cycle -> TURN.
  - TURN: rd_n=1, bus Z, one cycle -> IDLE. An RX byte costs RD_PULSE+2 cycles.
- Arbitration is per byte: an RX byte may interleave between bytes of one TX word; the byte index is preserved.
- usb_d is never driven while usb_rd_n=0, and never driven in the cycle after usb_rd_n rises.
- usb_txe_n and usb_rxf_n are used unsynchronised; board timing guarantees setup.

Optional Feature:
- Macro USB_STREAM_OVF_CNT_EN.
- Defined: adds output tx_ovf_count [15:0], a saturating count (sticks at 16'hFFFF) of tx_wr pulses dropped because the TX FIFO was full. Reset to 0 under reset.
- Undefined: the port and counter are absent; dropped words are silent.

Test Plan:
- DATA_WIDTH=16: push 16'hA55A, txe_n=0 -> usb_d shows 8'h5A then 8'hA5; one wr_n low pulse each, 4 cycles apart; FIFO then empty.
- txe_n=1 during TX_SETUP of byte 8'h11 -> no wr_n pulse; after txe_n=0, 8'h11 is strobed exactly once.
- Host supplies 8'h3C with rxf_n=0, RD_PULSE=4 -> rd_n low 4 cycles, usb_d Z throughout; rx_valid=1 with rx_data=8'h3C; rx_rd clears rx_valid.
- TX and RX requesting continuously -> grants alternate TX,RX,TX,...; TX word 32'h04030201 arrives intact as 01,02,03,04 despite interleaved reads.
- TX_LOG_SIZE=4: 20 tx_wr with txe_n=1 -> 15 stored, tx_have_space=0 from 8 words used; with the macro defined, tx_ovf_count=5.
- Assert reset during RX_STROBE -> rd_n=1 immediately, rx_valid=0, pointers 0; normal operation resumes after release.
